// File: rtl/delay_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : delay_cfg_pkg
// Purpose  : Shared defaults, event encoding and repeat-state encoding for
//            the delay configuration unit.
// Revision : 1.0 - initial release
// ============================================================================
package delay_cfg_pkg;

    localparam logic [31:0] c_DEF_STEP  = 32'd10000;
    localparam logic [31:0] c_DEF_MIN   = 32'd10000;
    localparam logic [31:0] c_DEF_MAX   = 32'hFFFF_0000;
    localparam logic [31:0] c_DEF_RESET = 32'd10000;

    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_INC  = 2'd1,
        EV_DEC  = 2'd2
    } ev_t;

    typedef enum logic [1:0] {
        REP_IDLE = 2'd0,
        REP_HOLD = 2'd1,
        REP_RPT  = 2'd2
    } rep_state_t;

endpackage
`default_nettype wire

// File: rtl/delay_config_unit_btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_conditioner
// Purpose  : 2-flop synchroniser, debouncer and rising-edge event generator
//            for one raw button; optional auto-repeat (DELAY_AUTOREPEAT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module btn_conditioner
    import delay_cfg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 1000,
    parameter int REPEAT_CYCLES   = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic ev
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_ev_edge;
    logic [CNT_W-1:0] r_db_cnt;
    logic             w_flip;

    // Flip on the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
    assign w_flip = (r_sync2 != r_stable) && (r_db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_stable  <= 1'b0;
            r_db_cnt  <= '0;
            r_ev_edge <= 1'b0;
        end else begin
            r_sync1   <= btn;
            r_sync2   <= r_sync1;
            if ((r_sync2 == r_stable) || w_flip)
                r_db_cnt <= '0;
            else
                r_db_cnt <= r_db_cnt + 1'b1;
            if (w_flip)
                r_stable <= ~r_stable;
            r_ev_edge <= w_flip && !r_stable;
        end
    end

`ifdef DELAY_AUTOREPEAT_EN
    localparam int RMAX   = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RCNT_W = (RMAX > 1) ? $clog2(RMAX + 1) : 1;

    rep_state_t        r_rep_state;
    rep_state_t        w_rep_next;
    logic [RCNT_W-1:0] r_rep_cnt;
    logic [RCNT_W-1:0] w_rep_cnt_next;
    logic              w_rep_fire;
    logic              r_rep_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_state <= REP_IDLE;
            r_rep_cnt   <= '0;
            r_rep_fire  <= 1'b0;
        end else begin
            r_rep_state <= w_rep_next;
            r_rep_cnt   <= w_rep_cnt_next;
            r_rep_fire  <= w_rep_fire;
        end
    end

    // A release in progress (w_flip while high) suppresses any further repeat.
    always_comb begin
        w_rep_next     = r_rep_state;
        w_rep_cnt_next = r_rep_cnt + 1'b1;
        w_rep_fire     = 1'b0;
        case (r_rep_state)
            REP_IDLE: begin
                w_rep_cnt_next = '0;
                if (w_flip && !r_stable)
                    w_rep_next = REP_HOLD;
            end
            REP_HOLD: begin
                if (!r_stable || w_flip) begin
                    w_rep_next     = REP_IDLE;
                    w_rep_cnt_next = '0;
                end else if (r_rep_cnt == RCNT_W'(HOLD_CYCLES - 1)) begin
                    w_rep_fire     = 1'b1;
                    w_rep_next     = REP_RPT;
                    w_rep_cnt_next = '0;
                end
            end
            REP_RPT: begin
                if (!r_stable || w_flip) begin
                    w_rep_next     = REP_IDLE;
                    w_rep_cnt_next = '0;
                end else if (r_rep_cnt == RCNT_W'(REPEAT_CYCLES - 1)) begin
                    w_rep_fire     = 1'b1;
                    w_rep_cnt_next = '0;
                end
            end
            default: begin
                w_rep_next     = REP_IDLE;
                w_rep_cnt_next = '0;
            end
        endcase
    end

    assign ev = r_ev_edge | r_rep_fire;
`else
    logic w_unused_rep_cfg;
    assign w_unused_rep_cfg = ^{32'(HOLD_CYCLES), 32'(REPEAT_CYCLES)};
    assign ev = r_ev_edge;
`endif

endmodule
`default_nettype wire

// File: rtl/delay_config_unit.sv
`default_nettype none
// ============================================================================
// Module   : delay_config_unit
// Purpose  : Button-driven per-channel delay registers with saturate/wrap
//            limits. Optional auto-repeat via macro DELAY_AUTOREPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module delay_config_unit
    import delay_cfg_pkg::*;
#(
    parameter int               WIDTH           = 32,
    parameter int               NUM_CH          = 4,
    parameter logic [WIDTH-1:0] STEP            = WIDTH'(c_DEF_STEP),
    parameter logic [WIDTH-1:0] MIN_VAL         = WIDTH'(c_DEF_MIN),
    parameter logic [WIDTH-1:0] MAX_VAL         = WIDTH'(c_DEF_MAX),
    parameter logic [WIDTH-1:0] RESET_VAL       = WIDTH'(c_DEF_RESET),
    parameter int               DEBOUNCE_CYCLES = 4,
    parameter int               HOLD_CYCLES     = 1000,
    parameter int               REPEAT_CYCLES   = 200,
    parameter int               SEL_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inc_btn,
    input  logic                    dec_btn,
    input  logic [SEL_W-1:0]        ch_sel,
    input  logic                    wrap_mode,
    output logic [NUM_CH*WIDTH-1:0] delay_val,
    output logic                    upd_pulse,
    output logic                    limit_pulse
);

    logic             w_inc_ev;
    logic             w_dec_ev;
    ev_t              w_ev;
    logic             w_ch_ok;
    logic [WIDTH-1:0] w_cur;
    logic [WIDTH-1:0] w_new;
    logic             w_lim;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_floor;
    logic [WIDTH-1:0] r_val [NUM_CH];
    logic             r_upd;
    logic             r_lim;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_inc (
        .clk(clk),
        .rst(rst),
        .btn(inc_btn),
        .ev (w_inc_ev)
    );

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_dec (
        .clk(clk),
        .rst(rst),
        .btn(dec_btn),
        .ev (w_dec_ev)
    );

    assign w_ch_ok = (32'(ch_sel) < 32'(NUM_CH));

    // Coincident inc/dec events cancel each other.
    always_comb begin
        w_ev = EV_NONE;
        if (w_inc_ev && !w_dec_ev)
            w_ev = EV_INC;
        else if (w_dec_ev && !w_inc_ev)
            w_ev = EV_DEC;
    end

    always_comb begin
        w_cur = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (ch_sel == SEL_W'(k))
                w_cur = r_val[k];
    end

    always_comb begin
        w_sum   = {1'b0, w_cur} + {1'b0, STEP};
        w_floor = {1'b0, MIN_VAL} + {1'b0, STEP};
        w_new   = w_cur;
        w_lim   = 1'b0;
        case (w_ev)
            EV_INC: begin
                if (w_sum <= {1'b0, MAX_VAL}) begin
                    w_new = w_sum[WIDTH-1:0];
                end else begin
                    w_lim = 1'b1;
                    w_new = wrap_mode ? MIN_VAL : MAX_VAL;
                end
            end
            EV_DEC: begin
                if ({1'b0, w_cur} >= w_floor) begin
                    w_new = w_cur - STEP;
                end else begin
                    w_lim = 1'b1;
                    w_new = wrap_mode ? MAX_VAL : MIN_VAL;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++)
                r_val[k] <= RESET_VAL;
            r_upd <= 1'b0;
            r_lim <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            r_lim <= 1'b0;
            if ((w_ev != EV_NONE) && w_ch_ok) begin
                for (int k = 0; k < NUM_CH; k++)
                    if (ch_sel == SEL_W'(k))
                        r_val[k] <= w_new;
                r_upd <= (w_new != w_cur);
                r_lim <= w_lim;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_out
        assign delay_val[k*WIDTH +: WIDTH] = r_val[k];
    end

    assign upd_pulse   = r_upd;
    assign limit_pulse = r_lim;

endmodule
`default_nettype wire

// File: doc/delay_config_unit.md
DELAY_CONFIG_UNIT -- requirements
Module: delay_config_unit

Interface
REQ-001 Param WIDTH, 32, bit width of each delay value.
REQ-002 Param NUM_CH, 4, number of independent delay channels (>=1).
REQ-003 Param STEP, 10000, increment/decrement amount.
REQ-004 Param MIN_VAL / MAX_VAL / RESET_VAL, 10000 / 32'hFFFF_0000 / 10000, limits and reset value; MIN_VAL <= RESET_VAL <= MAX_VAL.
REQ-005 Param DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a button level.
REQ-006 clk  in  1  single clock; all logic on posedge clk.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 inc_btn / dec_btn  in  1 each  raw asynchronous buttons.
REQ-009 ch_sel  in  max(1,$clog2(NUM_CH))  target channel.
REQ-010 wrap_mode  in  1  1 = wrap at limits, 0 = saturate.
REQ-011 delay_val  out  NUM_CH*WIDTH  channel k in bits [k*WIDTH +: WIDTH].
REQ-012 upd_pulse  out  1  one-cycle pulse when any channel changes.
REQ-013 limit_pulse  out  1  one-cycle pulse when an event clamped or wrapped.

Function
REQ-014 Each button passes a 2-flop synchroniser, then a debouncer: stable level flips only after raw synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch gap restarts the count.
REQ-015 Stable rising edge produces one event; falling edges produce none.
REQ-016 Event applied to channel ch_sel on the cycle after the stable edge; upd_pulse/limit_pulse asserted in the same cycle delay_val changes.
REQ-017 Total latency raw press -> delay_val update = 2 + DEBOUNCE_CYCLES + 1 cycles.
REQ-018 Increment: sum computed in WIDTH+1 bits; if val+STEP <= MAX_VAL new = val+STEP, else new = MIN_VAL (wrap_mode=1) or MAX_VAL (wrap_mode=0).
REQ-019 Decrement: if val >= MIN_VAL+STEP (WIDTH+1 bits) new = val-STEP, else new = MAX_VAL (wrap_mode=1) or MIN_VAL (wrap_mode=0).
REQ-020 limit_pulse asserted whenever the wrap/clamp branch is taken, even if value unchanged (already at limit); upd_pulse only if value differs.
REQ-021 Simultaneous inc and dec events in the same cycle: both discarded, no pulses.
REQ-022 ch_sel >= NUM_CH at application: event discarded, no pulses.
REQ-023 Unselected channels hold value; wrap_mode/ch_sel sampled only on the application cycle.

Reset
REQ-024 rst: all channels = RESET_VAL, synchronisers/stable levels/debounce counters = 0, upd_pulse = limit_pulse = 0, repeat state idle.
REQ-025 rst mid-debounce or mid-repeat aborts it; no event for that cycle.
REQ-026 Button held through reset release is seen as a new press after full latency.

Configuration
REQ-027 Macro DELAY_AUTOREPEAT_EN defined: stable level held for HOLD_CYCLES (param, 1000) after press issues a further event, then one every REPEAT_CYCLES (param, 200) while held; release returns to idle.
REQ-028 Macro undefined: exactly one event per press; HOLD_CYCLES/REPEAT_CYCLES unused, no repeat logic synthesised.

Structure
REQ-029 Package delay_cfg_pkg holds default STEP/MIN/MAX/RESET constants and the event enum {EV_NONE, EV_INC, EV_DEC}.
REQ-030 Sub-module btn_conditioner (synchroniser, debouncer, edge detect, optional auto-repeat), instantiated twice.
REQ-031 Top holds channel register array and up/down/limit arithmetic only.

Verification (WIDTH=32, NUM_CH=4, STEP=10000, MIN=10000, MAX=40000, DEBOUNCE_CYCLES=4)
REQ-032 Reset, inc_btn high 10 cycles, ch_sel=2 -> ch2 = 20000 exactly 7 cycles after press, one upd_pulse, others 10000.
REQ-033 ch0 at 40000, inc, wrap_mode=0 -> stays 40000, limit_pulse=1, upd_pulse=0; wrap_mode=1 -> 10000, both pulses.
REQ-034 ch1 at 10000, dec, wrap_mode=1 -> 40000; wrap_mode=0 -> 10000 with limit_pulse only.
REQ-035 inc_btn bouncing 1-0-1 at 2-cycle spacing then steady 10 cycles -> exactly one increment; both buttons pressed same cycle -> no change, no pulses.
REQ-036 rst asserted 2 cycles into debounce -> no update, all channels 10000; ch_sel=5 with NUM_CH=4 variant ch_sel width 3 -> event dropped.
REQ-037 DELAY_AUTOREPEAT_EN, HOLD=20, REPEAT=5, inc held 40 cycles post-debounce -> events at press, +20, +25, +30, +35, +40 cycles.
